slurm32_cpu_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the SLURM32 CPU core: one write port, `NUM_READ` registered read ports, optional write-to-read bypass, a hardwired zero register, and a hardware clear sweep after reset. It sits between instruction decode (read selects) and writeback (write port). It supersedes the fixed two-port file, which had no write enable, no bypass and no defined contents after reset.

---
 rtl/slurm32_cpu_pkg.sv | 19 +
 rtl/slurm32_regfile_bank.sv | 29 ++
 rtl/slurm32_cpu_regfile_mp.sv | 132 +++++++++++++
 tb/tb_slurm32_cpu_regfile_mp.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/slurm32_cpu_pkg.sv
// Shared SLURM32 CPU types and constants used by the register file.
package slurm32_cpu_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_t;

    // Where a read port's registered output comes from.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_BYP  = 2'd1,
        SRC_RAM  = 2'd2
    } rd_src_t;

    localparam int REG_ZERO     = 0;
    localparam int MAX_NUM_READ = 4;

endpackage

// File: rtl/slurm32_regfile_bank.sv
// 1-write/1-read synchronous RAM; read-first on a same-address collision.
module slurm32_regfile_bank #(
    parameter int REG_BITS = 8,
    parameter int BITS     = 32
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [REG_BITS-1:0] waddr_i,
    input  logic [BITS-1:0]     wdata_i,
    input  logic                re_i,
    input  logic [REG_BITS-1:0] raddr_i,
    output logic [BITS-1:0]     rdata_o
);

    logic [BITS-1:0] mem_q [2**REG_BITS];
    logic [BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slurm32_cpu_regfile_mp.sv
// Multi-read-port register file: one bank per read port sharing the write port,
// clear sweep after reset, optional write-to-read bypass and hardwired r0.
module slurm32_cpu_regfile_mp
    import slurm32_cpu_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int BITS     = 32,
    parameter int NUM_READ = 2,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [REG_BITS-1:0]          regIn_sel,
    input  logic [BITS-1:0]              regIn_data,
    input  logic                         regIn_we,
    input  logic [NUM_READ*REG_BITS-1:0] regOut_sel,
    output logic [NUM_READ*BITS-1:0]     regOut_data,
    input  logic                         is_executing,
    output logic                         clear_busy
);

    localparam int DEPTH = 2**REG_BITS;
    localparam logic [REG_BITS-1:0] ZERO_SEL = REG_BITS'(REG_ZERO);
    localparam logic [REG_BITS:0]   LAST_PTR = (REG_BITS+1)'(DEPTH-1);

    if ((NUM_READ < 1) || (NUM_READ > MAX_NUM_READ)) begin : g_bad_num_read
        $error("slurm32_cpu_regfile_mp: NUM_READ out of range");
    end

    regfile_state_t      state_q, state_d;
    logic [REG_BITS:0]   clr_ptr_q, clr_ptr_d;
    logic [BITS-1:0]     byp_data_q;
    logic                wr_en;
    logic [REG_BITS-1:0] wr_addr;
    logic [BITS-1:0]     wr_data;
    logic                capture;

    assign clear_busy = (state_q == CLEAR);
    assign capture    = (state_q == RUN) && is_executing && !RST;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_en     = 1'b0;
        wr_addr   = regIn_sel;
        wr_data   = regIn_data;
        case (state_q)
            CLEAR: begin
                wr_en     = !RST;
                wr_addr   = clr_ptr_q[REG_BITS-1:0];
                wr_data   = '0;
                clr_ptr_d = clr_ptr_q + (REG_BITS+1)'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wr_en = !RST && regIn_we && (regIn_sel != ZERO_SEL);
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            byp_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            // All ports capture together, so one bypass data register serves them all.
            if (capture) begin
                byp_data_q <= regIn_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        logic [REG_BITS-1:0] sel;
        logic [BITS-1:0]     bank_rd;
        rd_src_t             src_q, src_d;

        assign sel = regOut_sel[k*REG_BITS +: REG_BITS];

        slurm32_regfile_bank #(
            .REG_BITS (REG_BITS),
            .BITS     (BITS)
        ) u_bank (
            .clk_i   (CLK),
            .we_i    (wr_en),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .re_i    (capture),
            .raddr_i (sel),
            .rdata_o (bank_rd)
        );

        always_comb begin
            src_d = src_q;
            if (state_q == CLEAR) begin
                src_d = SRC_ZERO;
            end else if (is_executing) begin
                if (sel == ZERO_SEL) begin
                    src_d = SRC_ZERO;
                end else if (BYPASS && regIn_we && (regIn_sel == sel)) begin
                    src_d = SRC_BYP;
                end else begin
                    src_d = SRC_RAM;
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                src_q <= SRC_ZERO;
            end else begin
                src_q <= src_d;
            end
        end

        // Bank and bypass registers hold when not capturing, so the mux output holds too.
        always_comb begin
            case (src_q)
                SRC_BYP: regOut_data[k*BITS +: BITS] = byp_data_q;
                SRC_RAM: regOut_data[k*BITS +: BITS] = bank_rd;
                default: regOut_data[k*BITS +: BITS] = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_slurm32_cpu_regfile_mp.sv
// Bench: a bypass and a non-bypass instance driven in lockstep; table vectors
// feed a scoreboard queue, hand sequences cover reset and the clear sweep.
module tb_slurm32_cpu_regfile_mp;

    logic        CLK;
    logic        RST;
    logic [7:0]  regIn_sel;
    logic [31:0] regIn_data;
    logic        regIn_we;
    logic [15:0] regOut_sel;
    logic        is_executing;
    logic [63:0] rd_b, rd_n;
    logic        busy_b, busy_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [7:0]  wsel;
        logic [31:0] wdata;
        logic [7:0]  s0, s1;
        logic        ex;
        logic [31:0] eb0, eb1, en0, en1;
    } vec_t;

    typedef struct {
        logic [31:0] eb0, eb1, en0, en1;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];

    slurm32_cpu_regfile_mp #(.REG_BITS(8), .BITS(32), .NUM_READ(2), .BYPASS(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .regIn_sel(regIn_sel), .regIn_data(regIn_data),
        .regIn_we(regIn_we), .regOut_sel(regOut_sel), .regOut_data(rd_b),
        .is_executing(is_executing), .clear_busy(busy_b)
    );

    slurm32_cpu_regfile_mp #(.REG_BITS(8), .BITS(32), .NUM_READ(2), .BYPASS(1'b0)) dut_n (
        .CLK(CLK), .RST(RST), .regIn_sel(regIn_sel), .regIn_data(regIn_data),
        .regIn_we(regIn_we), .regOut_sel(regOut_sel), .regOut_data(rd_n),
        .is_executing(is_executing), .clear_busy(busy_n)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] wsel, input logic [31:0] wdata,
                                input logic [7:0] s0, input logic [7:0] s1, input logic ex,
                                input logic [31:0] eb0, input logic [31:0] eb1,
                                input logic [31:0] en0, input logic [31:0] en1);
        vec_t v;
        v.we = we; v.wsel = wsel; v.wdata = wdata; v.s0 = s0; v.s1 = s1; v.ex = ex;
        v.eb0 = eb0; v.eb1 = eb1; v.en0 = en0; v.en1 = en1;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        regIn_we     = v.we;
        regIn_sel    = v.wsel;
        regIn_data   = v.wdata;
        regOut_sel   = {v.s1, v.s0};
        is_executing = v.ex;
        e.eb0 = v.eb0; e.eb1 = v.eb1; e.en0 = v.en0; e.en1 = v.en1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({name, " byp p0"}, rd_b[31:0],  e.eb0);
        chk({name, " byp p1"}, rd_b[63:32], e.eb1);
        chk({name, " nob p0"}, rd_n[31:0],  e.en0);
        chk({name, " nob p1"}, rd_n[63:32], e.en1);
        regIn_we = 1'b0;
    endtask

    // Counts cycles clear_busy stays high while writes are being attempted.
    task automatic count_clear(input string name, input int limit, input int expect_cnt);
        int n = 0;
        regIn_we = 1'b1;
        while (busy_b && n < 1000 && n < limit) begin
            regIn_sel  = 8'(n + 7);
            regIn_data = 32'hBAD0_0000 | 32'(n);
            regOut_sel = {8'(n + 7), 8'(n + 7)};
            n++;
            @(posedge CLK);
            #1;
            if (n == 50) begin
                chk({name, " out0 mid-sweep"}, rd_b[31:0], 32'h0);
                chk({name, " busy_n mid-sweep"}, 32'(busy_n), 32'h1);
            end
        end
        regIn_we = 1'b0;
        chk({name, " clear cycles"}, 32'(n), 32'(expect_cnt));
    endtask

    task automatic pulse_reset(input string name);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk({name, " busy in reset"}, {busy_n, busy_b}, 32'h3);
        chk({name, " out in reset b"}, rd_b[31:0] | rd_b[63:32], 32'h0);
        chk({name, " out in reset n"}, rd_n[31:0] | rd_n[63:32], 32'h0);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; regIn_we = 1'b0; regIn_sel = '0; regIn_data = '0;
        regOut_sel = '0; is_executing = 1'b1;
        @(posedge CLK);
        pulse_reset("por");
        count_clear("por", 2000, 256);
        chk("por busy_n after", 32'(busy_n), 32'h0);

        // Dirty two entries, then confirm a fresh reset wipes them.
        apply(mk(1, 8'd10,  32'h11111111, 0, 0, 1, 0, 0, 0, 0), "pre w10");
        apply(mk(1, 8'd200, 32'h22222222, 8'd10, 8'd200, 1,
                 32'h11111111, 32'h22222222, 32'h11111111, 32'h0), "pre w200");
        pulse_reset("rst2");
        count_clear("rst2", 2000, 256);
        for (int a = 0; a < 256; a++) begin
            apply(mk(0, 0, 0, 8'(a), 8'(255 - a), 1, 0, 0, 0, 0), $sformatf("swept a=%0d", a));
        end

        tbl[0]  = mk(1, 8'd5,   32'hDEADBEEF, 8'd0,   8'd0,  1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 8'd0,   32'h0,        8'd5,   8'd5,  1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mk(1, 8'd0,   32'h12345678, 8'd0,   8'd0,  1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 8'd0,   32'h0,        8'd0,   8'd5,  1, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        tbl[4]  = mk(1, 8'd9,   32'hA5A5A5A5, 8'd9,   8'd5,  1, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        tbl[5]  = mk(0, 8'd0,   32'h0,        8'd9,   8'd9,  1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[6]  = mk(1, 8'd3,   32'h00000077, 8'd3,   8'd7,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[7]  = mk(0, 8'd0,   32'h0,        8'd1,   8'd2,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[8]  = mk(0, 8'd0,   32'h0,        8'd3,   8'd9,  1, 32'h77, 32'hA5A5A5A5, 32'h77, 32'hA5A5A5A5);
        tbl[9]  = mk(1, 8'd3,   32'hCAFEF00D, 8'd3,   8'd3,  1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h77, 32'h77);
        tbl[10] = mk(1, 8'd200, 32'h0BADF00D, 8'd200, 8'd10, 1, 32'h0BADF00D, 0, 0, 0);
        tbl[11] = mk(0, 8'd0,   32'h0,        8'd200, 8'd3,  1, 32'h0BADF00D, 32'hCAFEF00D, 32'h0BADF00D, 32'hCAFEF00D);
        tbl[12] = mk(1, 8'd255, 32'hFFFFFFFF, 8'd255, 8'd0,  1, 32'hFFFFFFFF, 0, 0, 0);
        tbl[13] = mk(0, 8'd0,   32'h0,        8'd255, 8'd255, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tbl[14] = mk(1, 8'd0,   32'h5555AAAA, 8'd0,   8'd255, 1, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF);
        tbl[15] = mk(0, 8'd0,   32'h0,        8'd0,   8'd0,  1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset mid-sweep at clr_ptr=100 with writes attempted throughout.
        pulse_reset("mid a");
        count_clear("mid a", 100, 100);
        regIn_we = 1'b1; regIn_sel = 8'd50; regIn_data = 32'hEEEEEEEE;
        pulse_reset("mid b");
        count_clear("mid b", 2000, 256);
        apply(mk(0, 0, 0, 8'd50,  8'd120, 1, 0, 0, 0, 0), "mid rd50");
        apply(mk(0, 0, 0, 8'd5,   8'd255, 1, 0, 0, 0, 0), "mid rd5");
        apply(mk(0, 0, 0, 8'd107, 8'd9,   1, 0, 0, 0, 0), "mid rd107");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
